// File: rtl/ascon_word_packer_pkg.sv
// Shared types and constants for the Ascon word packer.
package ascon_word_packer_pkg;

    localparam int unsigned BLOCK_WIDTH = 64;

    typedef logic [31:0] u32_t;
    typedef logic [63:0] u64_t;

    typedef enum logic [1:0] {
        PK_IDLE,
        PK_HALF,
        PK_FULL
    } packer_state_e;

    localparam logic DEST_AD = 1'b0;
    localparam logic DEST_PT = 1'b1;

    // Byte 0 of the bus word becomes the most significant byte.
    function automatic u32_t bswap32(input u32_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/ascon_word_packer_if.sv
// Word-stream handshake bundle between the subsystem bus and the packer.
interface ascon_word_packer_if #(
    parameter int unsigned WORD_WIDTH = 32
);
    logic                  word_valid_i;
    logic                  word_ready_o;
    logic [WORD_WIDTH-1:0] word_i;
    logic                  word_sel_i;
    logic                  word_last_i;

    modport master (
        output word_valid_i, word_i, word_sel_i, word_last_i,
        input  word_ready_o
    );

    modport slave (
        input  word_valid_i, word_i, word_sel_i, word_last_i,
        output word_ready_o
    );
endinterface

// File: rtl/ascon_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module ascon_sat_counter #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != {WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/ascon_word_packer.sv
// Packs 32-bit bus words into 64-bit blocks for the Ascon AD/PT FIFOs.
// Build option: define ASCON_PACKER_BSWAP_EN to byte-reverse each input word.
module ascon_word_packer
    import ascon_word_packer_pkg::*;
#(
    parameter int unsigned DATA_AW    = 7,
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    ascon_word_packer_if.slave       bus,
    output logic                     ad_push_o,
    output logic [BLOCK_WIDTH-1:0]   ad_o,
    input  logic                     ad_full_i,
    output logic                     pt_push_o,
    output logic [BLOCK_WIDTH-1:0]   pt_o,
    input  logic                     pt_full_i,
    output logic [DATA_AW-1:0]       ad_cnt_o,
    output logic [DATA_AW-1:0]       pt_cnt_o,
    output logic                     last_done_o
);

    packer_state_e         r_state;
    u64_t                  r_block;
    logic                  r_dest;
    logic                  r_last;
    logic                  r_last_done;

    logic [WORD_WIDTH-1:0] w_word;
    logic                  w_sel_full;
    logic                  w_push;
    logic                  w_xfer;

`ifdef ASCON_PACKER_BSWAP_EN
    assign w_word = bswap32(bus.word_i);
`else
    assign w_word = bus.word_i;
`endif

    // Only the latched destination's full flag matters.
    assign w_sel_full       = (r_dest == DEST_PT) ? pt_full_i : ad_full_i;
    assign w_push           = (r_state == PK_FULL) && !w_sel_full && !flush_i;
    assign bus.word_ready_o = (r_state != PK_FULL) && !flush_i && !rst;
    assign w_xfer           = bus.word_valid_i && bus.word_ready_o;

    assign ad_push_o   = w_push && (r_dest == DEST_AD);
    assign pt_push_o   = w_push && (r_dest == DEST_PT);
    assign ad_o        = r_block;
    assign pt_o        = r_block;
    assign last_done_o = r_last_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= PK_IDLE;
            r_block     <= '0;
            r_dest      <= DEST_AD;
            r_last      <= 1'b0;
            r_last_done <= 1'b0;
        end else if (flush_i) begin
            r_state     <= PK_IDLE;
            r_block     <= '0;
            r_dest      <= DEST_AD;
            r_last      <= 1'b0;
            r_last_done <= 1'b0;
        end else begin
            r_last_done <= w_push && r_last;
            case (r_state)
                PK_IDLE: begin
                    if (w_xfer) begin
                        r_block[63:32] <= w_word;
                        r_dest         <= bus.word_sel_i;
                        r_last         <= bus.word_last_i;
                        if (bus.word_last_i) begin
                            r_block[31:0] <= '0;
                            r_state       <= PK_FULL;
                        end else begin
                            r_state <= PK_HALF;
                        end
                    end
                end
                PK_HALF: begin
                    if (w_xfer) begin
                        r_block[31:0] <= w_word;
                        r_last        <= bus.word_last_i;
                        r_state       <= PK_FULL;
                    end
                end
                PK_FULL: begin
                    if (w_push) begin
                        r_state <= PK_IDLE;
                    end
                end
                default: r_state <= PK_IDLE;
            endcase
        end
    end

    ascon_sat_counter #(
        .WIDTH (DATA_AW)
    ) u_ad_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush_i),
        .inc_i (ad_push_o),
        .cnt_o (ad_cnt_o)
    );

    ascon_sat_counter #(
        .WIDTH (DATA_AW)
    ) u_pt_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush_i),
        .inc_i (pt_push_o),
        .cnt_o (pt_cnt_o)
    );

endmodule

// File: doc/ascon_word_packer.md
Name: ascon_word_packer

Overview:
- Upstream feeder for the Ascon wrapper's AD and PT FIFOs.
- Accepts a 32-bit word stream from the subsystem bus side (valid/ready, destination select, last flag).
- Packs pairs of words into 64-bit blocks and pushes each block into the selected FIFO (AD or PT), honouring the FIFO's full flag.
- Counts blocks pushed per destination so software can program ad_size/pt_size and check them.

Parameters:
- DATA_AW, 7, width of the per-destination block counters; matches the Ascon core size inputs.
- WORD_WIDTH, 32, input word width; BLOCK_WIDTH (package) must equal 2*WORD_WIDTH.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- flush_i  input  1  synchronous clear of held data and counters
- word_valid_i  input  1  input word valid
- word_ready_o  output  1  packer can accept a word
- word_i  input  WORD_WIDTH  input data word
- word_sel_i  input  1  destination: 0 = AD, 1 = PT; sampled with the first word of a block
- word_last_i  input  1  this word is the final word of the message part
- ad_push_o  output  1  push strobe to AD FIFO
- ad_o  output  BLOCK_WIDTH  block to AD FIFO
- ad_full_i  input  1  AD FIFO full
- pt_push_o  output  1  push strobe to PT FIFO
- pt_o  output  BLOCK_WIDTH  block to PT FIFO
- pt_full_i  input  1  PT FIFO full
- ad_cnt_o  output  DATA_AW  AD blocks pushed since last flush
- pt_cnt_o  output  DATA_AW  PT blocks pushed since last flush
- last_done_o  output  1  one-cycle pulse: block containing a last word was pushed

Behaviour:
- Reset (rst high, async): state IDLE; block register, dest, last flag, counters = 0; all push strobes, last_done_o = 0; word_ready_o = 0 while rst is high.
- Handshake: a word transfers on a rising edge with word_valid_i & word_ready_o. word_ready_o = (state != FULL).
- State IDLE, on transfer:
  - word -> block[63:32]; latch dest = word_sel_i and last = word_last_i.
  - If word_last_i: block[31:0] = 0, go to FULL.
  - Otherwise go to HALF.
- State HALF, on transfer:
  - word -> block[31:0]; last = word_last_i; go to FULL.
  - word_sel_i is ignored; dest stays as latched.
- State FULL:
  - word_ready_o = 0.
  - Selected push_o = !selected_full_i (combinational); the FIFO samples on the same edge. On push, go to IDLE.
  - While the selected FIFO is full, hold indefinitely with block stable.
- Output data:
  - ad_o and pt_o are both driven from the block register.
  - The non-selected push strobe is always 0; the non-selected full flag is ignored.
- Throughput: max 2 words per 3 cycles (IDLE, HALF, FULL). No skid buffer.
- Counters:
  - The selected counter increments on each push; it saturates at 2^DATA_AW-1, no wrap.
  - last_done_o is registered: high the cycle after a push whose last flag is set.
- flush_i: synchronous, highest priority. Next state IDLE; block, dest, last and counters cleared; any push in that cycle is suppressed; a word presented that cycle is not accepted (word_ready_o = 0 while flush_i is high).
- Reset mid-operation discards any half-packed or held block; no push is emitted.

Optional Feature:
- Macro ASCON_PACKER_BSWAP_EN.
- Defined: each input word is byte-reversed before packing (word[7:0] becomes byte 3, the most significant), for little-endian bus masters.
- Undefined: words are packed unmodified.
- All timing, handshakes and counters are identical in both builds.

Decomposition:
- ascon_pack:
  - BLOCK_WIDTH; u64_t; u32_t (new) for the word type.
  - enum packer_state_e {PK_IDLE, PK_HALF, PK_FULL}.
  - localparam DEST_AD = 1'b0, DEST_PT = 1'b1.
- One sub-module is natural: ascon_sat_counter (saturating up-counter with sync clear, width parameter), instantiated twice.

Test Plan:
- Reset then 4 words 0x01234567, 0x89ABCDEF, 0x0BADF00D, 0xCAFEBABE (sel=0, last on 4th), AD not full -> two ad_push_o pulses with 0x0123456789ABCDEF then 0x0BADF00DCAFEBABE; ad_cnt_o = 2; last_done_o pulses once, the cycle after the 2nd push; pt_push_o never high.
- 3 words to PT (sel=1, last on 3rd), 0x11111111, 0x22222222, 0x33333333 -> pt_o blocks 0x1111111122222222, 0x3333333300000000; pt_cnt_o = 2.
- Hold pt_full_i = 1 for 10 cycles while in FULL -> word_ready_o = 0, pt_push_o = 0, block stable; one push on the cycle full drops.
- First word sel=0, second word sel=1 -> block pushed to AD only.
- Push 130 AD blocks with DATA_AW=7 -> ad_cnt_o saturates at 127. Then flush_i while in HALF -> counters 0, state IDLE, no push.
- Assert rst asynchronously mid-FULL -> push strobes drop immediately; after release word_ready_o = 1. With ASCON_PACKER_BSWAP_EN, words 0x01234567, 0x89ABCDEF -> block 0x67452301EFCDAB89.
